// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch buffer.
// An entry pairs the fetch address (PC) with the instruction word read from it.
package fetch_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int WORD_WIDTH    = 32;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// First-word fall-through queue of {address, instruction} pairs between fetch and decode.
// Flush drops everything on a redirect; reset has priority over flush, push and pop.
import fetch_pkg::*;

module fetch_buffer #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_addr,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_addr,
  output logic [WIDTH-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  // Payload storage carries no reset; only pointers and count define validity.
  fetch_entry_t mem [DEPTH];
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // No bypass: a full buffer refuses a push even if the head leaves this cycle.
  assign in_ready  = (count_reg < CNT_W'(DEPTH)) && !reset;
  assign out_valid = (count_reg != '0) && !reset;
  assign count     = count_reg;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_entry.addr  = WORD_WIDTH'(in_addr);
  assign wr_entry.instr = WORD_WIDTH'(in_instr);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr_reg] <= wr_entry;
  end

  // Head is read combinationally so decode sees it the cycle after the push.
  assign head      = mem[rd_ptr_reg];
  assign out_addr  = out_valid ? WIDTH'(head.addr)  : '0;
  assign out_instr = out_valid ? WIDTH'(head.instr) : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios then random traffic, checked by a
// negedge monitor against a queue-based model of the buffer contents.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] instr;
  } pair_t;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_addr;
  logic [WIDTH-1:0] in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_addr;
  logic [WIDTH-1:0] out_instr;
  logic [$clog2(DEPTH):0] count;

  int compared   = 0;
  int mismatched = 0;
  bit reset_seen = 0;

  // Expected buffer contents, oldest first.
  pair_t model_q[$];

  fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour at a clock edge, from the inputs held during the cycle.
  task automatic model_update();
    bit    can_push;
    bit    can_pop;
    pair_t p;
    if (reset) begin
      model_q.delete();
      reset_seen = 1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      can_push = model_q.size() < DEPTH;
      can_pop  = model_q.size() != 0;
      if (can_pop && out_ready) void'(model_q.pop_front());
      if (can_push && in_valid) begin
        p.addr  = in_addr;
        p.instr = in_instr;
        model_q.push_back(p);
      end
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] ins,
                      input logic o);
    reset     = r;
    flush     = f;
    in_valid  = v;
    in_addr   = a;
    in_instr  = ins;
    out_ready = o;
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0);
  endtask

  task automatic push_one(input logic [WIDTH-1:0] a);
    step(0, 0, 1, a, $urandom, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1; k++) step(0, 0, 0, '0, '0, 1);
  endtask

  // Monitor: mid-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (reset_seen) begin
      chk("count", WIDTH'(count), WIDTH'(model_q.size()));
      chk("in_ready", WIDTH'(in_ready), WIDTH'((model_q.size() < DEPTH) && !reset));
      chk("out_valid", WIDTH'(out_valid), WIDTH'((model_q.size() != 0) && !reset));
      if (model_q.size() != 0 && !reset) begin
        chk("out_addr", out_addr, model_q[0].addr);
        chk("out_instr", out_instr, model_q[0].instr);
        if (out_ready)
          $display("pop  addr=%h instr=%h count=%0d", out_addr, out_instr, count);
      end else begin
        chk("out_addr_zero", out_addr, '0);
        chk("out_instr_zero", out_instr, '0);
      end
    end
  end

  initial begin
    // Reset, then a single push with decode stalled.
    step(1, 0, 0, '0, '0, 0);
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    idle();
    drain();

    // Fill to capacity, attempt a fifth push, then drain in order.
    for (int k = 0; k < 4; k++) push_one(k);
    step(0, 0, 1, 32'd4, 32'h5555_5555, 0);
    drain();

    // Full buffer with push and pop together: only the pop happens.
    for (int k = 0; k < 4; k++) push_one(k);
    step(0, 0, 1, 32'd99, 32'h9999_9999, 1);
    idle();
    drain();

    // Steady push+pop at count 2 across pointer wrap.
    push_one(32'h100);
    push_one(32'h101);
    for (int k = 0; k < 10; k++) step(0, 0, 1, k, $urandom, 1);
    drain();

    // Flush overrides a same-cycle push and pop.
    for (int k = 0; k < 3; k++) push_one(32'h200 + k);
    step(0, 1, 1, 32'h2FF, 32'h1234_5678, 1);
    idle();

    // Reset overrides flush and push; the next push appears alone.
    for (int k = 0; k < 3; k++) push_one(32'h300 + k);
    step(1, 1, 1, 32'h3FF, 32'h8765_4321, 0);
    step(1, 0, 1, 32'h3FE, 32'h8765_4320, 0);
    step(0, 0, 1, 32'h400, 32'hCAFE_F00D, 0);
    idle();
    drain();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom, $urandom,
           ($urandom_range(0, 9) < 6));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered entries; power of two, minimum 2.
REQ-002 Parameter WIDTH, default 32: width of address and instruction words.
REQ-003 Port clock  input  1  single clock; all state updates on posedge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  upstream offers an {address, instruction} pair this cycle.
REQ-006 Port in_ready  output  1  buffer accepts the offered pair this cycle.
REQ-007 Port in_addr  input  WIDTH  word address the instruction was fetched from (PC value).
REQ-008 Port in_instr  input  WIDTH  instruction word read from instruction memory.
REQ-009 Port flush  input  1  discard all buffered entries (taken branch / redirect).
REQ-010 Port out_valid  output  1  head entry is available to decode.
REQ-011 Port out_ready  input  1  decode consumes head entry this cycle.
REQ-012 Port out_addr  output  WIDTH  address of head entry.
REQ-013 Port out_instr  output  WIDTH  instruction of head entry.
REQ-014 Port count  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-015 Push occurs when in_valid && in_ready at a posedge; pop occurs when out_valid && out_ready at a posedge.
REQ-016 in_ready SHALL equal (count < DEPTH) && !reset; no bypass: full buffer rejects a push even when a pop occurs in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); head entry visible combinationally (first-word fall-through).
REQ-018 Push-to-out_valid latency SHALL be one cycle: entry pushed at edge N is visible after edge N.
REQ-019 out_addr and out_instr SHALL be driven 0 whenever out_valid is 0.
REQ-020 Entries SHALL leave in push order; out_addr/out_instr SHALL stay stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-022 Simultaneous push and pop with count == 0: pop not possible (out_valid 0); push proceeds, count becomes 1.
REQ-023 Write and read pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-024 flush at an edge SHALL set count, write pointer, read pointer to 0; any push or pop in that same cycle SHALL be discarded.
REQ-025 Cycle after flush: out_valid 0, in_ready 1; pushes accepted normally.
REQ-026 Storage array SHALL not require reset; only pointers and count carry reset state.

Reset
REQ-027 reset high at an edge SHALL set count, write pointer and read pointer to 0; reset has priority over flush, push, pop.
REQ-028 While reset is high: in_ready 0, out_valid 0, out_addr 0, out_instr 0, count 0 after the first reset edge.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; no stale entry SHALL appear after deassertion.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the default depth constant, word width constant and the entry type {addr, instr}.
REQ-031 No sub-module; pointers, count and storage SHALL be implemented inline in fetch_buffer.

Verification
REQ-032 Reset then push 0x0000_0010/0xDEAD_BEEF with out_ready 0 -> next cycle out_valid 1, out_addr 0x10, out_instr 0xDEADBEEF, count 1.
REQ-033 Push addresses 0,1,2,3 back-to-back, out_ready 0 -> count 4, in_ready 0; fifth push attempt ignored; drain yields 0,1,2,3 in order.
REQ-034 Fill to 4, then in_valid and out_ready both high one cycle -> pop of addr 0 only, count 3, pushed pair not stored.
REQ-035 count 2, continuous push+pop for 10 cycles with addr 0..9 -> count stays 2, outputs appear in order across pointer wrap.
REQ-036 count 3, assert flush with in_valid 1 and out_ready 1 -> next cycle count 0, out_valid 0, out_addr 0, in_ready 1.
REQ-037 count 3, assert reset with flush and in_valid high -> count 0, in_ready 0 during reset; after release first push appears alone.
